// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream packet buffer.
package axis_pkg;

    // Inbound side: normal storage, or discarding the tail of a truncated packet.
    typedef enum logic {
        W_ACCEPT,
        W_DROP
    } writer_state_t;

    // Outbound side: wait for a complete packet, prime the RAM read, stream beats.
    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_SEND
    } reader_state_t;

    // Number of byte strobes for a given data width.
    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The read register has its own synchronous clear so downstream outputs
// start from zero after reset.
module sdp_ram #(
    parameter int WIDTH      = 37,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_rst,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; holds its value while rd_en is low.
    always_ff @(posedge clk) begin
        if (rd_rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axis_packet_buffer.sv
// Store-and-forward AXI-Stream packet buffer. A packet is replayed on the
// master port only once its last beat is in the RAM. A packet that would
// fill the RAM while no complete packet is held is truncated: the filling
// beat is stored as the packet end and the remainder is discarded.
module axis_packet_buffer
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                    s01_axis_aclk,
    input  logic                    s01_axis_aresetn,
    input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
    input  logic                    s01_axis_tvalid,
    input  logic                    s01_axis_tlast,
    output logic                    s01_axis_tready,
    input  logic                    m01_axis_tready,
    output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
    output logic                    m01_axis_tvalid,
    output logic                    m01_axis_tlast,
    output logic [ADDR_WIDTH:0]     pkt_count,
    output logic [15:0]             drop_count,
    output logic                    overflow
);

    localparam int STRB_WIDTH  = strb_width(DATA_WIDTH);
    localparam int ENTRY_WIDTH = DATA_WIDTH + STRB_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0]   PTR_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   LAST_FREE = (ADDR_WIDTH + 1)'(DEPTH - 1);

    // Pointers carry a wrap bit above the RAM address.
    logic [ADDR_WIDTH:0]     wr_ptr_reg;
    logic [ADDR_WIDTH:0]     rd_ptr_reg;
    logic [ADDR_WIDTH:0]     occupancy;
    logic [ADDR_WIDTH:0]     pkt_count_reg;
    writer_state_t           w_state_reg;
    reader_state_t           r_state_reg;
    logic                    ready_en_reg;
    logic                    overflow_reg;
    logic                    m_valid_reg;
    logic [15:0]             drop_count_reg;

    logic                    full;
    logic                    s_ready;
    logic                    s_fire;
    logic                    null_beat;
    logic                    store;
    logic                    truncate;
    logic                    stored_last;
    logic                    pkt_in;
    logic                    m_fire;
    logic                    m_last;
    logic                    pkt_out;
    logic                    rd_en;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [ENTRY_WIDTH-1:0]  wr_data;
    logic [ENTRY_WIDTH-1:0]  rd_data;

    // rd_ptr_reg only advances when a beat leaves, so occupancy counts every
    // entry not yet handed to the consumer, including the one on the bus.
    assign occupancy = wr_ptr_reg - rd_ptr_reg;
    assign full      = (wr_ptr_reg[ADDR_WIDTH-1:0] == rd_ptr_reg[ADDR_WIDTH-1:0]) &&
                       (wr_ptr_reg[ADDR_WIDTH] != rd_ptr_reg[ADDR_WIDTH]);

    // ready_en_reg keeps tready low throughout reset and for the reset edge.
    assign s_ready   = ready_en_reg && ((w_state_reg == W_DROP) || !full);
    assign s_fire    = s01_axis_tvalid && s_ready;
    assign null_beat = (s01_axis_tstrb == '0) && !s01_axis_tlast;
    assign store     = s_fire && (w_state_reg == W_ACCEPT) && !null_beat;

    // With no complete packet held, nothing will ever drain the RAM, so the
    // beat taking the last free entry has to close the packet.
    assign truncate    = store && !s01_axis_tlast && (occupancy == LAST_FREE) &&
                         (pkt_count_reg == '0);
    assign stored_last = s01_axis_tlast || truncate;
    assign pkt_in      = store && stored_last;
    assign wr_data     = {stored_last, s01_axis_tstrb, s01_axis_tdata};

    assign m_fire  = m_valid_reg && m01_axis_tready;
    assign m_last  = rd_data[ENTRY_WIDTH-1];
    assign pkt_out = m_fire && m_last;

    // In R_SEND the read port prefetches the entry after the one on the bus.
    assign rd_en   = (r_state_reg == R_FETCH) ||
                     ((r_state_reg == R_SEND) && m_fire && !m_last);
    assign rd_addr = (r_state_reg == R_SEND) ? (rd_ptr_reg[ADDR_WIDTH-1:0] + ADDR_ONE)
                                             : rd_ptr_reg[ADDR_WIDTH-1:0];

    sdp_ram #(
        .WIDTH      (ENTRY_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (s01_axis_aclk),
        .wr_en   (store),
        .wr_addr (wr_ptr_reg[ADDR_WIDTH-1:0]),
        .wr_data (wr_data),
        .rd_rst  (!s01_axis_aresetn),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Writer FSM: stores beats, truncates on overflow, counts dropped beats.
    always_ff @(posedge s01_axis_aclk) begin
        if (!s01_axis_aresetn) begin
            w_state_reg    <= W_ACCEPT;
            wr_ptr_reg     <= '0;
            ready_en_reg   <= 1'b0;
            overflow_reg   <= 1'b0;
            drop_count_reg <= '0;
        end else begin
            ready_en_reg <= 1'b1;
            overflow_reg <= truncate;
            if (store) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            case (w_state_reg)
                W_ACCEPT: begin
                    if (truncate) begin
                        w_state_reg <= W_DROP;
                    end
                end
                W_DROP: begin
                    if (s_fire) begin
                        if (drop_count_reg != 16'hFFFF) begin
                            drop_count_reg <= drop_count_reg + 16'd1;
                        end
                        if (s01_axis_tlast) begin
                            w_state_reg <= W_ACCEPT;
                        end
                    end
                end
                default: w_state_reg <= W_ACCEPT;
            endcase
        end
    end

    // Complete-packet counter; a packet arriving and one leaving cancel out.
    always_ff @(posedge s01_axis_aclk) begin
        if (!s01_axis_aresetn) begin
            pkt_count_reg <= '0;
        end else if (pkt_in && !pkt_out) begin
            pkt_count_reg <= pkt_count_reg + PTR_ONE;
        end else if (pkt_out && !pkt_in) begin
            pkt_count_reg <= pkt_count_reg - PTR_ONE;
        end
    end

    // Reader FSM: waits for a complete packet, primes the RAM, then streams it.
    always_ff @(posedge s01_axis_aclk) begin
        if (!s01_axis_aresetn) begin
            r_state_reg <= R_IDLE;
            rd_ptr_reg  <= '0;
            m_valid_reg <= 1'b0;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    if (pkt_count_reg != '0) begin
                        r_state_reg <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    r_state_reg <= R_SEND;
                    m_valid_reg <= 1'b1;
                end
                R_SEND: begin
                    if (m_fire) begin
                        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
                        if (m_last) begin
                            m_valid_reg <= 1'b0;
                            r_state_reg <= R_IDLE;
                        end
                    end
                end
                default: begin
                    r_state_reg <= R_IDLE;
                    m_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign s01_axis_tready = s_ready;
    assign m01_axis_tvalid = m_valid_reg;
    assign m01_axis_tdata  = rd_data[DATA_WIDTH-1:0];
    assign m01_axis_tstrb  = rd_data[DATA_WIDTH +: STRB_WIDTH];
    assign m01_axis_tlast  = m_last;
    assign pkt_count       = pkt_count_reg;
    assign drop_count      = drop_count_reg;
    assign overflow        = overflow_reg;

endmodule

// File: tb/tb_axis_packet_buffer.sv
// Testbench for axis_packet_buffer: directed table and sequences for the
// corner cases, then randomized traffic against a queue-based reference.
module tb_axis_packet_buffer;

    localparam int DEPTH = 16;

    typedef struct packed {
        logic        last;
        logic [3:0]  strb;
        logic [31:0] data;
    } entry_t;

    typedef struct {
        bit          s_valid;
        logic [31:0] s_data;
        bit          s_last;
        bit          m_ready;
        bit          e_s_ready;
        bit          e_m_valid;
        logic [31:0] e_m_data;
        bit          e_m_last;
        int          e_pkt;
    } vec_t;

    logic        clk;
    logic        aresetn;
    logic [31:0] s_tdata;
    logic [3:0]  s_tstrb;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic        m_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb;
    logic        m_tvalid;
    logic        m_tlast;
    logic [4:0]  pkt_count;
    logic [15:0] drop_count;
    logic        overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state: every stored, not yet delivered entry in order.
    entry_t      q[$];
    entry_t      exp_q[$];
    bit          dropping;
    logic [15:0] drop_exp;
    bit          ovf_exp;
    bit          hold_pending;
    entry_t      held;

    axis_packet_buffer dut (
        .s01_axis_aclk    (clk),
        .s01_axis_aresetn (aresetn),
        .s01_axis_tdata   (s_tdata),
        .s01_axis_tstrb   (s_tstrb),
        .s01_axis_tvalid  (s_tvalid),
        .s01_axis_tlast   (s_tlast),
        .s01_axis_tready  (s_tready),
        .m01_axis_tready  (m_tready),
        .m01_axis_tdata   (m_tdata),
        .m01_axis_tstrb   (m_tstrb),
        .m01_axis_tvalid  (m_tvalid),
        .m01_axis_tlast   (m_tlast),
        .pkt_count        (pkt_count),
        .drop_count       (drop_count),
        .overflow         (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic int count_lasts();
        int n = 0;
        foreach (q[i]) if (q[i].last) n++;
        return n;
    endfunction

    task automatic idle_inputs();
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tstrb  = '0;
        s_tlast  = 1'b0;
    endtask

    task automatic drive_beat(input logic [31:0] data, input logic last);
        s_tvalid = 1'b1;
        s_tdata  = data;
        s_tstrb  = 4'hF;
        s_tlast  = last;
    endtask

    // Returns at the negedge right after the DUT has sampled reset released.
    task automatic do_reset(input int cycles);
        aresetn  = 1'b0;
        m_tready = 1'b0;
        idle_inputs();
        repeat (cycles) @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        q.delete();
        exp_q.delete();
        dropping     = 1'b0;
        drop_exp     = '0;
        ovf_exp      = 1'b0;
        hold_pending = 1'b0;
    endtask

    // Streams exp_q out with the consumer always ready, then expects silence.
    task automatic drain_expect(input string tag);
        int got = 0;
        int n = exp_q.size();
        int extra = 0;
        m_tready = 1'b1;
        for (int c = 0; c < 200 && got < n; c++) begin
            if (m_tvalid) begin
                check({tag, " beat"}, 64'({m_tlast, m_tstrb, m_tdata}), 64'(exp_q[got]));
                $display("[TB] %s out data=%h strb=%h last=%b", tag, m_tdata, m_tstrb, m_tlast);
                got++;
            end
            @(negedge clk);
        end
        check({tag, " beat count"}, 64'(got), 64'(n));
        repeat (6) begin
            if (m_tvalid) extra++;
            @(negedge clk);
        end
        check({tag, " extra beats"}, 64'(extra), 64'(0));
        check({tag, " pkt_count drained"}, 64'(pkt_count), 64'(0));
        m_tready = 1'b0;
        exp_q.delete();
    endtask

    // Applies one accepted inbound beat to the reference.
    task automatic model_accept(input logic last, input logic [3:0] strb, input logic [31:0] data,
                                input int pre_size, input int pre_lasts);
        entry_t e;
        if (dropping) begin
            if (drop_exp != 16'hFFFF) drop_exp = drop_exp + 16'd1;
            if (last) dropping = 1'b0;
        end else if (strb != 4'h0 || last) begin
            e = '{last: last, strb: strb, data: data};
            if (!last && pre_size == DEPTH - 1 && pre_lasts == 0) begin
                e.last   = 1'b1;
                dropping = 1'b1;
                ovf_exp  = 1'b1;
            end
            q.push_back(e);
        end
    endtask

    // One clock of randomized traffic, checked against the reference.
    task automatic model_cycle(input int ready_pct, input int last_pct, input bit drain);
        int pre_size  = q.size();
        int pre_lasts = count_lasts();
        check("rnd tready", 64'(s_tready), 64'(dropping || pre_size < DEPTH));
        check("rnd pkt_count", 64'(pkt_count), 64'(pre_lasts));
        check("rnd drop_count", 64'(drop_count), 64'(drop_exp));
        check("rnd overflow", 64'(overflow), 64'(ovf_exp));
        if (hold_pending)
            check("rnd stall hold", 64'({m_tvalid, m_tlast, m_tstrb, m_tdata}), 64'({1'b1, held}));
        ovf_exp  = 1'b0;
        m_tready = drain ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
        if (m_tvalid && m_tready) begin
            tests_run++;
            if (pre_lasts == 0) begin
                tests_failed++;
                $display("FAIL rnd beat without packet: got data=%h, expected no beat", m_tdata);
            end else begin
                if ({m_tlast, m_tstrb, m_tdata} !== q[0]) begin
                    tests_failed++;
                    $display("FAIL rnd out beat: got %h, expected %h", {m_tlast, m_tstrb, m_tdata}, q[0]);
                end
                void'(q.pop_front());
            end
            $display("[TB] rnd out data=%h strb=%h last=%b", m_tdata, m_tstrb, m_tlast);
        end
        hold_pending = m_tvalid && !m_tready;
        held         = {m_tlast, m_tstrb, m_tdata};
        if (drain) begin
            s_tvalid = dropping || (q.size() > 0 && !q[$].last);
            s_tdata  = $urandom;
            s_tstrb  = 4'hF;
            s_tlast  = 1'b1;
        end else begin
            s_tvalid = ($urandom_range(0, 99) < 70);
            s_tdata  = $urandom;
            s_tstrb  = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom);
            s_tlast  = ($urandom_range(0, 99) < last_pct);
        end
        if (s_tvalid && s_tready) model_accept(s_tlast, s_tstrb, s_tdata, pre_size, pre_lasts);
        @(negedge clk);
    endtask

    initial begin
        vec_t vecs [9];
        int   peak;
        int   got;
        int   ovf_cnt;
        int   extra;
        logic [31:0] b_data [4];

        // Packet A: three beats, consumer always ready.
        vecs[0] = '{1'b1, 32'hA000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 0};
        vecs[1] = '{1'b1, 32'hA000_0001, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 0};
        vecs[2] = '{1'b1, 32'hA000_0002, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 0};
        vecs[3] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1};
        vecs[4] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1};
        vecs[5] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b1, 32'hA000_0000, 1'b0, 1};
        vecs[6] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b1, 32'hA000_0001, 1'b0, 1};
        vecs[7] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b1, 32'hA000_0002, 1'b1, 1};
        vecs[8] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 0};

        // Reset: everything low while held, tready high right after release.
        aresetn  = 1'b0;
        m_tready = 1'b0;
        idle_inputs();
        repeat (4) begin
            @(negedge clk);
            check("reset outputs", 64'({s_tready, m_tvalid, m_tdata, m_tstrb, m_tlast,
                                        pkt_count, drop_count, overflow}), 64'(0));
        end
        aresetn = 1'b1;
        @(negedge clk);
        check("release tready", 64'(s_tready), 64'(1));
        check("release tvalid", 64'(m_tvalid), 64'(0));
        @(negedge clk);
        check("release tvalid idle", 64'(m_tvalid), 64'(0));
        $display("[TB] reset sequence done");

        // Single packet, table driven: checks latency and ordering.
        do_reset(2);
        foreach (vecs[i]) begin
            check("vec tready", 64'(s_tready), 64'(vecs[i].e_s_ready));
            check("vec tvalid", 64'(m_tvalid), 64'(vecs[i].e_m_valid));
            check("vec pkt_count", 64'(pkt_count), 64'(vecs[i].e_pkt));
            if (vecs[i].e_m_valid) begin
                check("vec out beat", 64'({m_tlast, m_tstrb, m_tdata}),
                      64'({vecs[i].e_m_last, 4'hF, vecs[i].e_m_data}));
                $display("[TB] vec out data=%h last=%b", m_tdata, m_tlast);
            end
            m_tready = vecs[i].m_ready;
            if (vecs[i].s_valid) drive_beat(vecs[i].s_data, vecs[i].s_last);
            else idle_inputs();
            @(negedge clk);
        end

        // Two 2-beat packets with the consumer toggling ready.
        do_reset(2);
        b_data = '{32'hB000_0000, 32'hB000_0001, 32'hB100_0000, 32'hB100_0001};
        peak = 0;
        got = 0;
        hold_pending = 1'b0;
        for (int c = 0; c < 60 && got < 4; c++) begin
            if (hold_pending)
                check("toggle stall hold", 64'({m_tvalid, m_tlast, m_tstrb, m_tdata}), 64'({1'b1, held}));
            if (int'(pkt_count) > peak) peak = int'(pkt_count);
            m_tready = (c % 2 == 0);
            if (c < 4) begin
                check("toggle tready", 64'(s_tready), 64'(1));
                drive_beat(b_data[c], (c % 2 == 1));
            end else begin
                idle_inputs();
            end
            if (m_tvalid && m_tready) begin
                check("toggle out beat", 64'({m_tlast, m_tstrb, m_tdata}),
                      64'({(got % 2 == 1), 4'hF, b_data[got]}));
                $display("[TB] toggle out data=%h last=%b", m_tdata, m_tlast);
                got++;
            end
            hold_pending = m_tvalid && !m_tready;
            held         = {m_tlast, m_tstrb, m_tdata};
            @(negedge clk);
        end
        check("toggle beat count", 64'(got), 64'(4));
        check("toggle peak pkt_count", 64'(peak), 64'(2));
        m_tready = 1'b0;

        // 20-beat packet into a 16-entry buffer with the consumer stalled.
        do_reset(2);
        ovf_cnt = 0;
        for (int b = 1; b <= 20; b++) begin
            check("trunc tready", 64'(s_tready), 64'(1));
            if (overflow) ovf_cnt++;
            drive_beat(32'(b), (b == 20));
            @(negedge clk);
        end
        idle_inputs();
        repeat (3) begin
            if (overflow) ovf_cnt++;
            @(negedge clk);
        end
        check("trunc overflow pulses", 64'(ovf_cnt), 64'(1));
        check("trunc drop_count", 64'(drop_count), 64'(4));
        check("trunc pkt_count", 64'(pkt_count), 64'(1));
        $display("[TB] trunc drop_count=%0d", drop_count);
        for (int b = 1; b <= 16; b++) exp_q.push_back('{last: (b == 16), strb: 4'hF, data: 32'(b)});
        drain_expect("trunc");

        // Fill completely with four 4-beat packets, then offer one more beat.
        do_reset(2);
        for (int k = 0; k < 16; k++) begin
            check("fill tready", 64'(s_tready), 64'(1));
            drive_beat(32'h5000 + 32'(k), (k % 4 == 3));
            @(negedge clk);
        end
        drive_beat(32'h5EEE, 1'b1);
        repeat (3) begin
            check("full tready low", 64'(s_tready), 64'(0));
            @(negedge clk);
        end
        check("full tvalid", 64'(m_tvalid), 64'(1));
        check("full first beat", 64'({m_tlast, m_tstrb, m_tdata}), 64'({1'b0, 4'hF, 32'h5000}));
        $display("[TB] full out data=%h last=%b", m_tdata, m_tlast);
        m_tready = 1'b1;
        @(negedge clk);
        m_tready = 1'b0;
        check("full tready after drain", 64'(s_tready), 64'(1));
        @(negedge clk);
        idle_inputs();
        check("full tready refilled", 64'(s_tready), 64'(0));
        for (int k = 1; k < 16; k++) exp_q.push_back('{last: (k % 4 == 3), strb: 4'hF, data: 32'h5000 + 32'(k)});
        exp_q.push_back('{last: 1'b1, strb: 4'hF, data: 32'h5EEE});
        drain_expect("full");

        // Reset while packet C is half sent.
        do_reset(2);
        for (int k = 0; k < 4; k++) begin
            drive_beat(32'hC000_0000 + 32'(k), (k == 3));
            @(negedge clk);
        end
        idle_inputs();
        m_tready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 2; c++) begin
            if (m_tvalid) begin
                check("midreset out beat", 64'(m_tdata), 64'(32'hC000_0000 + 32'(got)));
                $display("[TB] midreset out data=%h", m_tdata);
                got++;
            end
            @(negedge clk);
        end
        check("midreset beats before reset", 64'(got), 64'(2));
        aresetn = 1'b0;
        @(negedge clk);
        check("midreset tvalid", 64'(m_tvalid), 64'(0));
        check("midreset pkt_count", 64'(pkt_count), 64'(0));
        aresetn = 1'b1;
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (m_tvalid) extra++;
        end
        check("midreset stale beats", 64'(extra), 64'(0));
        m_tready = 1'b0;

        // Randomized traffic against the reference model.
        do_reset(2);
        repeat (600) model_cycle(80, 30, 1'b0);
        repeat (600) model_cycle(20, 5, 1'b0);
        repeat (600) model_cycle(50, 15, 1'b0);
        for (int c = 0; c < 400 && (q.size() > 0 || dropping); c++) model_cycle(100, 0, 1'b1);
        check("rnd drained", 64'(q.size()), 64'(0));
        idle_inputs();
        m_tready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
